// File: rtl/scanout_pkg.sv
// Shared types and helpers for the VRAM scanout feeder: pixel formats, FSM states, defaults.
package scanout_pkg;

  localparam int unsigned HActiveDefault = 640;
  localparam int unsigned VActiveDefault = 480;
  localparam int unsigned StrideDefault  = 1024;

  typedef struct packed {
    logic       m;
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {StIdle, StFetch} state_e;

  // Replicate the top bits so full-scale 5-bit maps to full-scale 8-bit.
  function automatic rgb888_t rgb555_to_888(rgb555_t p);
    rgb888_t c;
    c.r = {p.r, p.r[4:2]};
    c.g = {p.g, p.g[4:2]};
    c.b = {p.b, p.b[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Small synchronous FIFO; push and pop in the same cycle are both honoured, even when full or empty.
module scanout_fifo #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop, bypass;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

  // Push+pop on an empty FIFO passes the word straight through without storing it.
  assign bypass  = empty_o & push_i & pop_i;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~bypass & (~full_o | pop_i);
  assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_scanout.sv
// Raster-order VRAM fetch, RGB555->888 expansion and rdy/en pixel handoff to the video stage.
module vram_scanout
  import scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = HActiveDefault,
  parameter int unsigned V_ACTIVE   = VActiveDefault,
  parameter int unsigned STRIDE     = StrideDefault,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              rdy,
  output logic [23:0]       data,
  output logic              en,
  output logic              frame_start,
  output logic              underflow,
  input  logic              clr_underflow
);

  localparam int unsigned XW   = $clog2(H_ACTIVE);
  localparam int unsigned YW   = $clog2(V_ACTIVE);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [XW-1:0]     x_q, x_d, rx_q, rx_d;
  logic [YW-1:0]     y_q, y_d, ry_q, ry_d;
  logic [CntW-1:0]   out_q, out_d;
  logic              drop_q, drop_d;
  logic              pend_q, pend_d;
  logic              en_q, fs_q, uf_q, uf_d;
  logic [23:0]       data_q;

  logic              gnt_take, rv_take, want;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [24:0]       fifo_wdata, fifo_rdata;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     credit_sum;
  logic              unused_full;

  assign unused_full = fifo_full;

  assign credit_sum = {1'b0, fifo_count} + {1'b0, out_q};
  assign mem_rd     = (state_q == StFetch) && (credit_sum < (CntW + 1)'(FIFO_DEPTH));
  assign mem_addr   = line_q + ADDR_W'(x_q);
  assign gnt_take   = mem_rd & mem_gnt;
  // Responses still in flight from before a reset are dropped until the first new grant.
  assign rv_take    = mem_rvalid & ~drop_q;

  assign fifo_push  = rv_take;
  assign fifo_wdata = {rgb555_to_888(rgb555_t'(mem_rdata)), (rx_q == '0) && (ry_q == '0)};
  assign want       = rdy | pend_q;
  assign fifo_pop   = want & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          line_d  = fb_base;
          x_d     = '0;
          y_d     = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (gnt_take) begin
          if (x_q == XW'(H_ACTIVE - 1)) begin
            x_d = '0;
            if (y_q == YW'(V_ACTIVE - 1)) begin
              y_d = '0;
              if (enable) line_d = fb_base;
              else        state_d = StIdle;
            end else begin
              y_d    = y_q + YW'(1);
              line_d = line_q + ADDR_W'(STRIDE);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    drop_d = drop_q & ~gnt_take;
    rx_d   = rx_q;
    ry_d   = ry_q;
    case ({gnt_take, rv_take})
      2'b10:   out_d = out_q + CntW'(1);
      2'b01:   out_d = out_q - CntW'(1);
      default: out_d = out_q;
    endcase
    // Response-side raster position identifies pixel (0,0) for the frame tag.
    if (rv_take) begin
      if (rx_q == XW'(H_ACTIVE - 1)) begin
        rx_d = '0;
        ry_d = (ry_q == YW'(V_ACTIVE - 1)) ? '0 : ry_q + YW'(1);
      end else begin
        rx_d = rx_q + XW'(1);
      end
    end
    pend_d = want & fifo_empty;
    uf_d   = clr_underflow ? 1'b0 : (uf_q | (want & fifo_empty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      line_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      out_q   <= '0;
      drop_q  <= 1'b1;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      en_q    <= fifo_pop;
      fs_q    <= fifo_pop & fifo_rdata[0];
      uf_q    <= uf_d;
      if (fifo_pop) data_q <= fifo_rdata[24:1];
    end
  end

  assign data        = data_q;
  assign en          = en_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

  scanout_fifo #(
    .Width (25),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on a reduced 8x4 frame with a scoreboarded memory model.
module tb_vram_scanout;

  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;

  logic        clk = 1'b0;
  logic        rst, enable, mem_rd, mem_gnt, mem_rvalid, rdy, en, frame_start;
  logic        underflow, clr_underflow;
  logic [18:0] fb_base, mem_addr;
  logic [15:0] mem_rdata;
  logic [23:0] data;

  always #5 clk = ~clk;

  vram_scanout #(
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .STRIDE     (1024),
    .ADDR_W     (19),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fb_base       (fb_base),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rdy           (rdy),
    .data          (data),
    .en            (en),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .clr_underflow (clr_underflow)
  );

  // Memory model: grant gated by gnt_en, in-order response after lat_m1+1 cycles.
  logic        gnt_en, fixed;
  logic [1:0]  lat_m1;
  logic [15:0] fixed_val;
  logic [23:0] color_exp;
  logic [3:0]  v_pipe = '0;
  logic [18:0] a_pipe [4];

  assign mem_gnt    = mem_rd & gnt_en;
  assign mem_rvalid = v_pipe[0];
  assign mem_rdata  = fixed ? fixed_val : a_pipe[0][15:0];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      v_pipe[i] <= v_pipe[i+1];
      a_pipe[i] <= a_pipe[i+1];
    end
    v_pipe[3]      <= 1'b0;
    v_pipe[lat_m1] <= mem_gnt;
    a_pipe[lat_m1] <= mem_addr;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp888(input logic [15:0] h);
    logic [4:0] r, g, b;
    r = h[4:0];
    g = h[9:5];
    b = h[14:10];
    return {r, r[4:2], g, g[4:2], b, b[4:2]};
  endfunction

  typedef struct {
    logic [18:0] addr;
    logic        first;
  } exp_t;

  exp_t        q[$];
  int          ex, ey, gnt_cnt, en_cnt, rv_cnt, max_sum, ovf_hits;
  logic [18:0] exp_line, exp_base_next, last_gnt;

  function automatic logic [18:0] next_exp();
    return ((ex == 0 && ey == 0) ? exp_base_next : exp_line) + 19'(ex);
  endfunction

  // Monitor: checks each grant address and each delivered pixel in order.
  initial begin
    exp_t        e;
    logic [18:0] ea;
    int          sum;
    ex = 0; ey = 0; gnt_cnt = 0; en_cnt = 0; rv_cnt = 0; max_sum = 0; ovf_hits = 0;
    exp_line = '0; last_gnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        ex = 0; ey = 0; gnt_cnt = 0; en_cnt = 0; rv_cnt = 0;
      end else begin
        if (en) begin
          en_cnt++;
          check("en_has_exp", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("pix", data, fixed ? color_exp : exp888(e.addr[15:0]));
            check("frame_start", frame_start, e.first);
          end
        end
        sum = gnt_cnt - en_cnt;
        if (sum > max_sum) max_sum = sum;
        if (dut.fifo_full && dut.fifo_push && !dut.fifo_pop) ovf_hits++;
        if (mem_rvalid) rv_cnt++;
        if (mem_rd && mem_gnt) begin
          if (ex == 0 && ey == 0) exp_line = exp_base_next;
          ea = exp_line + 19'(ex);
          check("addr", mem_addr, ea);
          last_gnt = mem_addr;
          q.push_back('{ea, (ex == 0 && ey == 0)});
          gnt_cnt++;
          if (ex == HA - 1) begin
            ex = 0;
            exp_line = exp_line + 19'd1024;
            ey = (ey == VA - 1) ? 0 : ey + 1;
          end else begin
            ex++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rdy();
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
  endtask

  task automatic color_case(input logic [15:0] v, input logic [23:0] e);
    rst = 1'b1; enable = 1'b0;
    tick(2);
    rst = 1'b0; fixed = 1'b1; fixed_val = v; color_exp = e; enable = 1'b1;
    tick(4);
    pulse_rdy();
    check("color_en", en, 1);
    tick(3);
    check("color_hold", data, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g0, k;
    rst = 1'b1; enable = 1'b0; fb_base = '0; rdy = 1'b0; clr_underflow = 1'b0;
    gnt_en = 1'b1; lat_m1 = 2'd0; fixed = 1'b0; fixed_val = '0; color_exp = '0;
    exp_base_next = '0;

    tick(3);
    check("rst_en", en, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_uf", underflow, 0);
    check("rst_data", data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_addr", mem_addr, 0);

    color_case(16'h7FFF, 24'hFFFFFF);
    color_case(16'h001F, 24'hFF0000);
    color_case(16'h8000, 24'h000000);
    color_case(16'h4210, 24'h848484);

    // Steady raster fetch; base change mid-frame must only apply from the next frame.
    rst = 1'b1; enable = 1'b0;
    tick(2);
    fixed = 1'b0; rst = 1'b0; enable = 1'b1;
    tick(12);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) begin
        fb_base = 19'h7F800;
        exp_base_next = 19'h7F800;
      end
      pulse_rdy();
      tick(7);
    end
    check("uf_main", underflow, 0);

    // Grant stall: address held, FIFO drains, underflow latches.
    gnt_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse_rdy();
      tick(1);
      if (i == 5) check("stall_addr_mid", mem_addr, next_exp());
    end
    check("stall_rd", mem_rd, 1);
    check("stall_addr_end", mem_addr, next_exp());
    check("stall_uf", underflow, 1);
    gnt_en = 1'b1;
    tick(15);
    clr_underflow = 1'b1;
    tick(1);
    clr_underflow = 1'b0;
    check("uf_clr", underflow, 0);

    // rdy held high against a full FIFO.
    n0 = en_cnt;
    rdy = 1'b1;
    tick(40);
    rdy = 1'b0;
    tick(2);
    check("burst_pops", 32'((en_cnt - n0) >= 8), 1);

    // Drop enable mid-frame: finish frame then idle.
    enable = 1'b0;
    for (int i = 0; i < 75; i++) begin
      pulse_rdy();
      tick(1);
    end
    tick(4);
    check("last_addr", last_gnt, 19'h00407);
    check("idle_rd", mem_rd, 0);
    check("drained", q.size(), 0);
    check("frame_whole", gnt_cnt % 32, 0);
    g0 = gnt_cnt;
    tick(10);
    check("idle_no_gnt", gnt_cnt, g0);
    check("uf_pre", underflow, 1);

    // Mid-line reset with reads in flight; stale responses must be ignored.
    lat_m1 = 2'd2;
    enable = 1'b1;
    k = 0;
    while ((gnt_cnt - rv_cnt) < 3 && k < 40) begin
      tick(1);
      k++;
    end
    check("out3", 32'((gnt_cnt - rv_cnt) >= 3), 1);
    rst = 1'b1; enable = 1'b0;
    tick(1);
    check("mrst_en", en, 0);
    check("mrst_rd", mem_rd, 0);
    check("mrst_uf", underflow, 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    pulse_rdy();
    tick(4);
    check("stale_en", en_cnt, 0);
    check("stale_uf", underflow, 1);
    check("stale_rd", mem_rd, 0);

    check("credit_max", 32'(max_sum <= 8), 1);
    check("full_push", ovf_hits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Upstream feeder for the HDMI video output stage. Fetches a 640x480 frame in raster order from PSX VRAM (RGB555 halfwords) over a simple read port.
- Expands each pixel to 24-bit RGB and buffers it in a small FIFO.
- Hands pixels to the video stage on its rdy/en handshake: rdy in, 24-bit data plus en out.

Parameters:
- H_ACTIVE, 640, pixels per line fetched.
- V_ACTIVE, 480, lines per frame.
- STRIDE, 1024, VRAM halfwords per line.
- ADDR_W, 19, VRAM halfword address width.
- FIFO_DEPTH, 8, pixel buffer entries (power of two, >=4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  scanout enable; sampled only at frame boundaries
- fb_base  in  ADDR_W  frame base halfword address; latched at frame start
- mem_rd  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; in-order responses, any latency >=1
- mem_rdata  in  16  VRAM halfword: [4:0] R, [9:5] G, [14:10] B, [15] mask (ignored)
- rdy  in  1  video stage ready for one pixel (single-cycle pulse)
- data  out  24  pixel {R8,G8,B8}
- en  out  1  data valid / load strobe to video stage, one cycle per pixel
- frame_start  out  1  pulses with en for pixel (0,0) of each frame
- underflow  out  1  sticky: a rdy had to wait on an empty FIFO
- clr_underflow  in  1  clears underflow

Behaviour:
- Reset: all outputs 0, FSM IDLE, x=y=0, FIFO empty, credits=0, rdy_pending=0. Reset mid-frame discards FIFO contents and outstanding reads. Any mem_rvalid arriving after reset is ignored until the first new request is granted.
- FSM:
  - IDLE: mem_rd=0. If enable: latch fb_base into base, x=y=0, go to FETCH.
  - FETCH: mem_rd=1 while (FIFO count + outstanding) < FIFO_DEPTH. mem_addr = base + y*STRIDE + x, from a registered line-address accumulator; no multiplier.
  - On mem_gnt: x++; when x=H_ACTIVE-1, x=0, y++, and line address += STRIDE.
  - On grant of the last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1): if enable, relatch fb_base, x=y=0, stay in FETCH with no bubble cycle; else go to IDLE.
- mem_addr/mem_rd are held stable until mem_gnt. Address arithmetic wraps modulo 2^ADDR_W.
- Outstanding counter: +1 on mem_gnt, -1 on mem_rvalid; simultaneous events leave it unchanged.
- Pixel expansion on write into the FIFO: R8={r5,r5[4:2]}, G8={g5,g5[4:2]}, B8={b5,b5[4:2]}.
- FIFO tag bit marks pixel (0,0) of each frame and drives frame_start.
- Output handshake:
  - rdy sets rdy_pending.
  - When rdy_pending and FIFO non-empty, the next cycle drives en=1 with data=head, pops the FIFO, and clears rdy_pending.
  - Latency from rdy to en is exactly 1 cycle when the FIFO is non-empty.
  - data holds its value between en pulses.
  - rdy while rdy_pending=1 is absorbed; there are no double pops.
- Underflow: set when rdy_pending=1 and the FIFO is empty for a cycle. clr_underflow has priority over a simultaneous set.
- FIFO full with mem_rvalid cannot occur under the credit rule. The bench asserts this never happens.
- FIFO simultaneous push/pop when full or empty: a push and pop in the same cycle are both honoured; count is unchanged.
- Draining continues in IDLE until the FIFO is empty.

Decomposition:
- Package scanout_pkg: H_ACTIVE/V_ACTIVE/STRIDE defaults, rgb555_t packed struct, rgb888_t, state enum {IDLE, FETCH}, rgb555_to_888 function.
- One sub-module: scanout_fifo, a synchronous FIFO of 25 bits (24 pixel + tag) with push/pop/full/empty/count.

Test Plan:
- Reset, then enable=1, fb_base=0, 1-cycle memory, rdy pulsed every 8 cycles -> addresses 0..639, then 1024..1663, etc. 307200 en pulses per frame; frame_start on the 1st en and the 307201st.
- mem_rdata=16'h7FFF -> data=24'hFFFFFF. 16'h001F -> 24'hFF0000. 16'h8000 -> 24'h000000. 16'h4210 -> 24'h848484.
- mem_gnt held low for 20 cycles while rdy keeps pulsing -> mem_addr stable, FIFO drains, underflow=1. After gnt resumes, the next en carries the correct next pixel with none skipped. clr_underflow -> 0.
- rdy constantly high with the FIFO pre-filled to 8 -> exactly one pop per en with correct order. Never more than FIFO_DEPTH outstanding + buffered.
- enable dropped mid-frame -> fetch continues to address base+479*1024+639, then IDLE with mem_rd=0. fb_base changed mid-frame takes effect only at the next frame.
- rst asserted mid-line with 3 reads outstanding -> next cycle en=0, mem_rd=0, underflow=0. Stale mem_rvalid pulses are not pushed into the FIFO.
